// File: rtl/bpsk_upsample.sv
// bpsk_upsample
// Zero-insertion interpolator for the BPSK transmit chain. Mapped symbols
// (+1 = 2'b01, -1 = 2'b11) are buffered in a small FIFO and emitted one
// sample per enabled clock. Each symbol is followed by UPS-1 zero samples.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   sym_i         mapped symbol (passed through unchecked)
//   sym_vld_i     sym_i valid
//   sym_rdy_o     FIFO can accept (combinational, low during reset)
//   en_i          sample-rate enable
//   sample_o      interpolated sample (registered)
//   sample_vld_o  sample_o updated this cycle (registered)
//   sym_start_o   sample_o carries a symbol, phase 0 (registered)
//   underrun_o    one-cycle pulse, FIFO empty at a symbol boundary in RUN
//   level_o       FIFO occupancy
//
// FSM states:
//   state | meaning
//   IDLE  | no symbol period in progress, waiting for en_i and a symbol
//   RUN   | emitting a symbol period, phase tracks the sample within it
module bpsk_upsample #(
    parameter int UPS   = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [1:0]          sym_i,
    input  logic                       sym_vld_i,
    output logic                       sym_rdy_o,
    input  logic                       en_i,
    output logic signed [1:0]          sample_o,
    output logic                       sample_vld_o,
    output logic                       sym_start_o,
    output logic                       underrun_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(UPS);

    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_LAST = PW'(UPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [PW-1:0]     phase;

    logic [1:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [1:0]        head;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign sym_rdy_o = !full && !rst;
    assign push      = sym_vld_i && sym_rdy_o;
    assign head      = mem[rd_ptr];
    assign level_o   = level;

    // A pop happens whenever a new symbol period may begin: from IDLE, or
    // at phase 0 in RUN. Uses level before the edge, so a symbol pushed
    // into an empty FIFO is never popped in the same cycle.
    assign pop = en_i && !empty && ((state == IDLE) || (phase == '0));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sym_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            sample_o     <= '0;
            sample_vld_o <= 1'b0;
            sym_start_o  <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            sample_vld_o <= 1'b0;
            sym_start_o  <= 1'b0;
            underrun_o   <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (pop) begin
                        sample_o     <= head;
                        sample_vld_o <= 1'b1;
                        sym_start_o  <= 1'b1;
                        phase        <= PH_ONE;
                        state        <= RUN;
                    end else begin
                        sample_o <= '0;
                    end
                end
                RUN: begin
                    // With en_i low everything holds, including sample_o.
                    if (en_i) begin
                        sample_vld_o <= 1'b1;
                        if (phase != '0) begin
                            sample_o <= '0;
                            phase    <= (phase == PH_LAST) ? '0 : phase + PW'(1);
                        end else if (pop) begin
                            sample_o    <= head;
                            sym_start_o <= 1'b1;
                            phase       <= PH_ONE;
                        end else begin
                            // Boundary with nothing buffered: emit a zero and
                            // drop to IDLE so the next symbol realigns phase.
                            sample_o   <= '0;
                            underrun_o <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bpsk_upsample.md
# bpsk_upsample

Zero-insertion interpolator for the BPSK transmit chain. It sits directly after the symbol mapper. It accepts mapped 2-bit signed symbols (+1 as 2'b01, −1 as 2'b11) through a valid/ready handshake and buffers them in a small FIFO. It then emits one sample per enabled clock: the symbol on the first sample of each symbol period and zeros on the remaining UPS−1 samples. The output feeds the pulse-shaping FIR.

## Interface
- UPS, default 8: samples per symbol. Legal range 2..256.
- DEPTH, default 4: input FIFO depth. Power of two, ≥2.
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sym_i  input  signed 2  mapped symbol from the mapper. Passed through unmodified; 2'b10 is not validated.
- sym_vld_i  input  1  sym_i valid.
- sym_rdy_o  output  1  FIFO can accept. Equals !full && !rst (combinational).
- en_i  input  1  sample-rate enable. Output advances only when it is high.
- sample_o  output  signed 2  interpolated sample (registered).
- sample_vld_o  output  1  sample_o updated this cycle (registered).
- sym_start_o  output  1  sample_o carries a symbol, i.e. phase 0 (registered).
- underrun_o  output  1  one-cycle pulse: FIFO empty at a symbol boundary while running.
- level_o  output  clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Push:** a push occurs on sym_vld_i && sym_rdy_o.
- **Pop:** only the output FSM pops.
- **Occupancy:** level updates by +push−pop in the same edge.
- **Push/pop ordering:**
  - A pop requires level>0 before the edge, so a symbol pushed into an empty FIFO cannot be popped in the same cycle.
  - When the FIFO is full, ready is low, so simultaneous push and pop cannot occur at full.
- **Phase counter:** 0..UPS−1, wraps from UPS−1 to 0.
- **FSM states:** IDLE and RUN.
- **IDLE:**
  - Phase is held at 0.
  - If en_i=0 or level=0: sample_o←0, sample_vld_o←0, sym_start_o←0.
  - If en_i=1 and level>0: pop; sample_o←head, sample_vld_o←1, sym_start_o←1, phase←1, state←RUN.
- **RUN, en_i=0:** everything is frozen (phase, state, FIFO read side); sample_vld_o←0, sym_start_o←0, sample_o holds.
- **RUN, en_i=1, phase≠0:** sample_o←0, sample_vld_o←1, sym_start_o←0, phase←(phase+1) mod UPS.
- **RUN, en_i=1, phase=0, level>0:** pop; sample_o←head, sample_vld_o←1, sym_start_o←1, phase←1.
- **RUN, en_i=1, phase=0, level=0 (underrun):**
  - sample_o←0, sample_vld_o←1, sym_start_o←0, underrun_o←1 for one cycle.
  - state←IDLE.
  - Restart follows the IDLE rule, so symbol boundaries realign to the first new symbol.
- underrun_o is 0 in every other case.
- Pushes continue normally in every state.

## Timing
- **Reset** (synchronous, takes effect on the edge with rst=1):
  - state=IDLE, phase=0, FIFO empty, level_o=0.
  - sample_o=0, sample_vld_o=0, sym_start_o=0, underrun_o=0.
  - sym_rdy_o=0 while rst=1.
  - Reset mid-symbol discards buffered symbols and the partial period; no underrun pulse is generated.
- **Latency:** a symbol accepted at edge k into an empty FIFO, with the FSM in IDLE and en_i=1, appears on sample_o after edge k+1 with sym_start_o=1.
- **Steady state** (en_i=1 continuously, FIFO never empty):
  - sym_start_o is high exactly every UPS cycles.
  - Zero samples fill the UPS−1 cycles between.
  - One pop occurs per UPS cycles.
- **Throughput:** input sustains one symbol per UPS enabled cycles. The FIFO absorbs up to DEPTH symbols of burst.

## Test plan
- **Basic interpolation:** UPS=4; after reset push +1, −1, +1 with en_i=1 constant → sample_o = 01,00,00,00,11,00,00,00,01,00,00,00; sym_start_o on samples 0, 4 and 8; then underrun_o pulses once at sample 12 and the FSM returns to IDLE.
- **Full FIFO backpressure:** DEPTH=4, en_i=0, push 6 symbols with vld high → sym_rdy_o drops after 4 accepted, level_o=4; raise en_i → remaining 2 accepted as pops free slots, all 6 emitted in order.
- **Enable gating:** toggle en_i 1,0,1,0 during RUN with UPS=8 → phase advances only on en_i=1 cycles, sample_vld_o mirrors en_i delayed one cycle, symbol spacing equals 8 enabled cycles.
- **Push into empty at boundary:** RUN at phase 0, level 0, push in the same cycle → underrun_o=1, zero emitted; next edge IDLE restart pops that symbol with sym_start_o=1.
- **Reset mid-operation:** assert rst for one cycle at phase 3 with level 2 → next cycle all outputs 0, level_o=0, no underrun_o; a subsequent push restarts cleanly at phase 0.
- **UPS=2 minimum:** continuous ±1 stream → alternating symbol/zero, one pop every 2 cycles, no underrun while the FIFO stays non-empty.
